vc_flit_sink: RTL and testbench

Parametrised, synthesisable successor to the testbench flit sink. It terminates one router output channel with per-VC flit buffers and a programmable consumption rate driven by an LFSR instead of `$dist_uniform`. It returns per-VC credits and checks per-VC packet framing, plus, optionally, head-flit sequence numbers. It exposes sticky error flags and consumption counters, so the same block serves simulation benches and FPGA traffic tests.

---
 rtl/rtr_sink_pkg.sv | 13 +
 rtl/vc_sink_fifo.sv | 34 +++
 rtl/vc_flit_sink.sv | 105 ++++++++++
 tb/tb_vc_flit_sink.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtr_sink_pkg.sv
// rtr_sink_pkg: shared constants, LFSR step, error bit positions and framing state encoding for the flit sink
package rtr_sink_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam int RATE_SCALE = 1024;
  localparam int ERR_OVF = 0;
  localparam int ERR_PROTO = 1;
  localparam int ERR_SEQ = 2;
  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_e;
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/vc_sink_fifo.sv
// vc_sink_fifo: single-VC flit buffer holding {tail, data}, power-of-two depth with occupancy count
module vc_sink_fifo #(
  parameter int depth = 8,
  parameter int width = 65
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(depth);
  logic [width-1:0] mem [depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == (AW+1)'(depth);
endmodule

// File: rtl/vc_flit_sink.sv
// vc_flit_sink: per-VC buffered flit sink with LFSR-paced round-robin consumption, credit return and framing checks
// Defining VC_FLIT_SINK_SEQ_CHECK_EN adds per-VC head-flit sequence checking on error[2].
module vc_flit_sink
  import rtr_sink_pkg::*;
#(
  parameter int num_vcs = 4,
  parameter int depth_per_vc = 8,
  parameter int flit_data_width = 64,
  parameter int seq_width = 16,
  parameter int consume_rate = 1024,
  parameter logic [LFSR_W-1:0] lfsr_seed = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flit_valid,
  input  logic [$clog2(num_vcs)-1:0] flit_vc,
  input  logic                       flit_head,
  input  logic                       flit_tail,
  input  logic [flit_data_width-1:0] flit_data,
  output logic                       credit_valid,
  output logic [$clog2(num_vcs)-1:0] credit_vc,
  output logic [2:0]                 error,
  output logic [31:0]                flits_consumed,
  output logic [31:0]                pkts_consumed
);
  localparam int VW = $clog2(num_vcs);
  logic [LFSR_W-1:0] lfsr;
  logic [VW-1:0] ptr, gnt;
  logic consume, found, pop_tail, ovf, proto_err, seq_err;
  logic [2:0] err_now;
  logic [num_vcs-1:0] empty, full, push_v, pop_v;
  logic [flit_data_width:0] rdata [num_vcs];
  pkt_state_e st [num_vcs];
  pkt_state_e cur_st, nxt_st;
  for (genvar g = 0; g < num_vcs; g++) begin : g_vc
    assign push_v[g] = flit_valid && flit_vc == VW'(g) && !full[g];
    assign pop_v[g] = found && gnt == VW'(g);
    vc_sink_fifo #(.depth(depth_per_vc), .width(flit_data_width + 1)) u_fifo (
      .clk(clk), .reset_n(reset_n), .push(push_v[g]), .pop(pop_v[g]),
      .wdata({flit_tail, flit_data}), .rdata(rdata[g]), .empty(empty[g]), .full(full[g])
    );
  end
  assign consume = consume_rate >= RATE_SCALE || int'(lfsr[9:0]) < consume_rate;
  // Descending scan so the VC closest after the pointer wins.
  always_comb begin
    found = 1'b0;
    gnt = ptr;
    for (int i = num_vcs - 1; i >= 0; i--)
      if (consume && !empty[(int'(ptr) + i) % num_vcs]) begin
        found = 1'b1;
        gnt = VW'((int'(ptr) + i) % num_vcs);
      end
  end
  assign pop_tail = rdata[gnt][flit_data_width];
  assign cur_st = st[flit_vc];
  assign nxt_st = (flit_head || cur_st == IN_PKT) && !flit_tail ? IN_PKT : IDLE;
  assign proto_err = flit_valid && (cur_st == IDLE ? !flit_head : flit_head);
  assign ovf = flit_valid && full[flit_vc];
`ifdef VC_FLIT_SINK_SEQ_CHECK_EN
  logic [seq_width-1:0] exp_seq [num_vcs];
  logic [seq_width-1:0] rx_seq;
  assign rx_seq = flit_data[seq_width-1:0];
  assign seq_err = flit_valid && flit_head && rx_seq != exp_seq[flit_vc];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < num_vcs; i++) exp_seq[i] <= '0;
    end else if (flit_valid && flit_head) begin
      exp_seq[flit_vc] <= rx_seq + 1'b1;
    end
`else
  assign seq_err = 1'b0;
`endif
  always_comb begin
    err_now = '0;
    err_now[ERR_OVF] = ovf;
    err_now[ERR_PROTO] = proto_err;
    err_now[ERR_SEQ] = seq_err;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < num_vcs; i++) st[i] <= IDLE;
    end else if (flit_valid) begin
      st[flit_vc] <= nxt_st;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lfsr <= lfsr_seed;
      ptr <= '0;
      credit_valid <= 1'b0;
      credit_vc <= '0;
      error <= '0;
      flits_consumed <= '0;
      pkts_consumed <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      error <= error | err_now;
      credit_valid <= found;
      if (found) begin
        credit_vc <= gnt;
        ptr <= int'(gnt) == num_vcs - 1 ? '0 : gnt + 1'b1;
        flits_consumed <= flits_consumed + 32'd1;
        pkts_consumed <= pkts_consumed + 32'(pop_tail);
      end
    end
endmodule

// File: tb/tb_vc_flit_sink.sv
// tb_vc_flit_sink: randomized and directed traffic against a queue-based sink model; credits checked by a scoreboard monitor
module tb_vc_flit_sink;
  localparam int NV = 4;
  localparam int D = 8;
  localparam int DW = 64;
  localparam int SW = 16;
  localparam int RATE = 512;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef VC_FLIT_SINK_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif
  logic clk = 0, reset_n = 0, flit_valid = 0, flit_head = 0, flit_tail = 0;
  logic [1:0] flit_vc = '0;
  logic [DW-1:0] flit_data = '0;
  logic credit_valid;
  logic [1:0] credit_vc;
  logic [2:0] error;
  logic [31:0] flits_consumed, pkts_consumed;

  vc_flit_sink #(
    .num_vcs(NV), .depth_per_vc(D), .flit_data_width(DW), .seq_width(SW),
    .consume_rate(RATE), .lfsr_seed(SEED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flit_valid(flit_valid), .flit_vc(flit_vc),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_data(flit_data),
    .credit_valid(credit_valid), .credit_vc(credit_vc), .error(error),
    .flits_consumed(flits_consumed), .pkts_consumed(pkts_consumed)
  );

  always #5 clk = ~clk;

  typedef struct {int vc; int cyc;} cred_t;
  cred_t exp_q[$];
  cred_t mon_e;
  int mq [NV][$];
  int m_ptr, cyc, checks, failures;
  logic [15:0] m_lfsr;
  logic [31:0] m_flits, m_pkts;
  logic [2:0] m_err;
  bit m_inpkt [NV];
  logic [SW-1:0] m_seq [NV];
  bit gen_in [NV];
  logic [SW-1:0] gen_seq [NV];
  logic [SW-1:0] seqs [4];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      mq[i].delete();
      m_inpkt[i] = 0;
      m_seq[i] = '0;
      gen_in[i] = 0;
      gen_seq[i] = '0;
    end
    m_ptr = 0;
    m_lfsr = SEED;
    m_flits = 0;
    m_pkts = 0;
    m_err = '0;
    exp_q.delete();
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < NV; i++) if (mq[i].size() != 0) return 1;
    return 0;
  endfunction

  // One clock edge of the sink as described behaviourally: pick, check, pop, push.
  function automatic void model_step(bit v, int vc, bit h, bit t, logic [DW-1:0] d);
    bit cons, drop;
    int g;
    cyc++;
    cons = RATE >= 1024 || int'(m_lfsr[9:0]) < RATE;
    g = -1;
    if (cons)
      for (int i = 0; i < NV; i++)
        if (g < 0 && mq[(m_ptr + i) % NV].size() > 0) g = (m_ptr + i) % NV;
    drop = v && mq[vc].size() == D;
    if (v) begin
      if (drop) m_err[0] = 1;
      if ((!m_inpkt[vc] && !h) || (m_inpkt[vc] && h)) m_err[1] = 1;
      if (t) m_inpkt[vc] = 0;
      else if (h) m_inpkt[vc] = 1;
      if (SEQ_ON && h) begin
        if (d[SW-1:0] != m_seq[vc]) m_err[2] = 1;
        m_seq[vc] = d[SW-1:0] + 1'b1;
      end
    end
    if (g >= 0) begin
      if (mq[g].pop_front() != 0) m_pkts++;
      m_flits++;
      m_ptr = (g + 1) % NV;
      exp_q.push_back('{g, cyc});
    end
    if (v && !drop) mq[vc].push_back(int'(t));
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endfunction

  always @(posedge clk)
    if (reset_n) model_step(flit_valid, int'(flit_vc), flit_head, flit_tail, flit_data);

  always @(negedge clk)
    if (reset_n) begin
      if (credit_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL credit_unexpected: got vc %0d required no credit (cycle %0d)", credit_vc, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (int'(credit_vc) != mon_e.vc || mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL credit: got vc %0d at cycle %0d required vc %0d at cycle %0d",
                     credit_vc, cyc, mon_e.vc, mon_e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL credit_missing: got none required vc %0d at cycle %0d", exp_q[0].vc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end

  task automatic cycle(input bit v, input int vc, input bit h, input bit t, input logic [DW-1:0] d);
    @(negedge clk);
    chk("error", 32'(error), 32'(m_err));
    chk("flits_consumed", flits_consumed, m_flits);
    chk("pkts_consumed", pkts_consumed, m_pkts);
    flit_valid = v;
    flit_vc = 2'(vc);
    flit_head = h;
    flit_tail = t;
    flit_data = d;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, '0);
  endtask

  task automatic legal_flit();
    int vc;
    bit h, t;
    vc = $urandom_range(0, NV - 1);
    h = !gen_in[vc];
    t = h ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
    cycle(1, vc, h, t, {32'($urandom), 16'($urandom), gen_seq[vc]});
    if (h) gen_seq[vc]++;
    if (t) gen_in[vc] = 0;
    else if (h) gen_in[vc] = 1;
  endtask

  task automatic assert_reset();
    reset_n = 0;
    flit_valid = 0;
    #1;
    chk("rst_credit_valid", 32'(credit_valid), 0);
    chk("rst_credit_vc", 32'(credit_vc), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_flits", flits_consumed, 0);
    chk("rst_pkts", pkts_consumed, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1;
  endtask

  task automatic drain();
    int n = 0;
    while (model_busy() && n < 300) begin
      idle();
      n++;
    end
    chk("drain_within_budget", 32'(n < 300), 1);
    idle();
    idle();
  endtask

  initial begin
    assert_reset();
    repeat (300) if ($urandom_range(0, 2) == 0) idle(); else legal_flit();
    idle();
    chk("legal_traffic_no_proto_seq", 32'(error[2:1]), 0);
    drain();
    #2 assert_reset();
    for (int i = 0; i < 40; i++) cycle(1, 0, 1, 1, DW'(i));
    idle();
    chk("burst_ovf_set", 32'(error[0]), 1);
    chk("burst_no_proto", 32'(error[1]), 0);
    drain();
    #2 assert_reset();
    seqs = '{16'd0, 16'd1, 16'd3, 16'd4};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1, 0, 1, 1, DW'(seqs[i]));
      else idle();
      if (i > 0) chk("seq_gap_flag", 32'(error[2]), 32'(SEQ_ON && i - 1 >= 2));
    end
    chk("seq_no_proto", 32'(error[1]), 0);
    cycle(1, 0, 0, 0, '0);
    idle();
    chk("proto_body_in_idle", 32'(error[1]), 1);
    cycle(1, 0, 1, 0, DW'(5));
    cycle(1, 0, 1, 0, DW'(6));
    idle();
    chk("proto_sticky", 32'(error[1]), 1);
    repeat (300) cycle($urandom_range(0, 1), $urandom_range(0, NV - 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), {32'($urandom), 32'($urandom)});
    drain();
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, 1, DW'(i));
    #2 assert_reset();
    repeat (10) idle();
    cycle(1, 0, 1, 1, '0);
    drain();
    chk("credits_outstanding", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
